// File: rtl/reg_arb_pkg.sv
// Shared types and constants for the register write-port arbiter.
package reg_arb_pkg;

  localparam int ARB_AW = 5;
  localparam int ARB_DW = 32;

  // Writes that target this register are consumed but never reach the file.
  localparam logic [ARB_AW-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    FORCE
  } arb_state_e;

  typedef struct packed {
    logic [ARB_AW-1:0] dest;
    logic [ARB_DW-1:0] val;
  } arb_entry_t;

endpackage

// File: rtl/reg_arb_fifo.sv
// Pending-result FIFO for mul/div writebacks. It exposes the per-slot
// valid/destination view so the hazard unit can see every buffered target.
module reg_arb_fifo
  import reg_arb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = ARB_AW
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  arb_entry_t                 push_entry_i,
  input  logic                       pop_i,
  output arb_entry_t                 head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [DEPTH-1:0]           slot_valid_o,
  output logic [DEPTH-1:0][AW-1:0]   slot_dest_o
);

  localparam int PW = $clog2(DEPTH);

  arb_entry_t      mem_q [DEPTH];
  logic [PW-1:0]   rd_ptr_q;
  logic [PW-1:0]   wr_ptr_q;
  logic [PW:0]     count_q;

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // Pointer and occupancy bookkeeping; pointers wrap because DEPTH is a power of 2.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
    end
  end

  // Entry storage carries no reset; occupancy alone decides what is live.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= push_entry_i;
  end

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      slot_valid_o[i] = {1'b0, PW'(i) - rd_ptr_q} < count_q;
      slot_dest_o[i]  = mem_q[i].dest;
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Register-file write-port arbiter: WB always owns the port, mul/div results
// queue and drain in idle WB cycles, and a starvation counter requests a
// one-cycle WB stall. Optional macro REG_WRITE_ARBITER_BYPASS_EN lets an md
// result write straight through when nothing is queued and WB is idle.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4,
  parameter int AW           = ARB_AW,
  parameter int DW           = ARB_DW
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wb_en_i,
  input  logic [AW-1:0] wb_dest_i,
  input  logic [DW-1:0] wb_val_i,
  input  logic          md_valid_i,
  input  logic [AW-1:0] md_dest_i,
  input  logic [DW-1:0] md_val_i,
  output logic          md_ready_o,
  output logic          stall_req_o,
  input  logic [AW-1:0] q_src1_i,
  input  logic [AW-1:0] q_src2_i,
  output logic          hit1_o,
  output logic          hit2_o,
  output logic          rf_we_o,
  output logic [AW-1:0] rf_dest_o,
  output logic [DW-1:0] rf_val_o,
  output logic          proto_err_o
);

  localparam int CW   = $clog2(DEPTH);
  localparam int AGEW = $clog2(STARVE_LIMIT + 1);

  arb_state_e              state_q, state_d;
  logic [AGEW-1:0]         age_q, age_d;
  logic                    proto_err_q, proto_err_d;

  logic                    fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [CW:0]             fifo_count;
  arb_entry_t              fifo_head, push_entry;
  logic [DEPTH-1:0]        slot_valid;
  logic [DEPTH-1:0][AW-1:0] slot_dest;

  logic                    md_bypass, head_blocked, starve_hit, last_out;
  logic                    sel_valid;
  logic [AW-1:0]           sel_dest;
  logic [DW-1:0]           sel_val;

  assign md_ready_o   = ~fifo_full;
  assign head_blocked = wb_en_i & ~fifo_empty & ~rst_i;
  assign fifo_pop     = ~wb_en_i & ~fifo_empty & ~rst_i;

`ifdef REG_WRITE_ARBITER_BYPASS_EN
  assign md_bypass = fifo_empty & ~wb_en_i & (state_q != FORCE) & md_valid_i & ~rst_i;
`else
  assign md_bypass = 1'b0;
`endif

  assign fifo_push        = md_valid_i & md_ready_o & ~md_bypass & ~rst_i;
  assign push_entry.dest  = md_dest_i;
  assign push_entry.val   = md_val_i;

  // Starvation fires when this blocked cycle brings the age to STARVE_LIMIT-1.
  assign starve_hit = (int'(age_q) >= STARVE_LIMIT - 2);
  assign last_out   = fifo_pop & ~fifo_push & (fifo_count == (CW+1)'(1));

  assign stall_req_o = (state_q == FORCE);
  assign proto_err_o = proto_err_q;

  reg_arb_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .push_i       (fifo_push),
    .push_entry_i (push_entry),
    .pop_i        (fifo_pop),
    .head_o       (fifo_head),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .count_o      (fifo_count),
    .slot_valid_o (slot_valid),
    .slot_dest_o  (slot_dest)
  );

  // Write-port mux: WB first, then the FIFO head, then a bypassing md result.
  always_comb begin
    sel_valid = 1'b0;
    sel_dest  = '0;
    sel_val   = '0;
    if (wb_en_i) begin
      sel_valid = 1'b1;
      sel_dest  = wb_dest_i;
      sel_val   = wb_val_i;
    end else if (fifo_pop) begin
      sel_valid = 1'b1;
      sel_dest  = fifo_head.dest;
      sel_val   = fifo_head.val;
    end else if (md_bypass) begin
      sel_valid = 1'b1;
      sel_dest  = md_dest_i;
      sel_val   = md_val_i;
    end
    rf_we_o   = sel_valid && (sel_dest != AW'(REG_ZERO));
    rf_dest_o = sel_dest;
    rf_val_o  = sel_val;
  end

  // Hazard hits cover every live slot (including one popping now) and a bypassing request.
  always_comb begin
    hit1_o = 1'b0;
    hit2_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_valid[i] && (slot_dest[i] == q_src1_i)) hit1_o = 1'b1;
      if (slot_valid[i] && (slot_dest[i] == q_src2_i)) hit2_o = 1'b1;
    end
    if (md_bypass && (md_dest_i == q_src1_i)) hit1_o = 1'b1;
    if (md_bypass && (md_dest_i == q_src2_i)) hit2_o = 1'b1;
    if (q_src1_i == AW'(REG_ZERO)) hit1_o = 1'b0;
    if (q_src2_i == AW'(REG_ZERO)) hit2_o = 1'b0;
  end

  // Next-state logic for the age counter, the starvation FSM and the sticky error flag.
  always_comb begin
    age_d       = age_q;
    state_d     = state_q;
    proto_err_d = proto_err_q | (wb_en_i & (state_q == FORCE));

    if (fifo_empty || fifo_pop) begin
      age_d = '0;
    end else if (head_blocked && (age_q < AGEW'(STARVE_LIMIT))) begin
      age_d = age_q + AGEW'(1);
    end

    case (state_q)
      IDLE: begin
        if (fifo_push) state_d = WAIT;
      end
      WAIT: begin
        if (last_out) begin
          state_d = IDLE;
        end else if (head_blocked && starve_hit) begin
          state_d = FORCE;
        end
      end
      FORCE: begin
        if (fifo_pop) state_d = last_out ? IDLE : WAIT;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      age_q       <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      age_q       <= age_d;
      proto_err_q <= proto_err_d;
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for reg_write_arbiter (DEPTH=2, STARVE_LIMIT=4).
module tb_reg_write_arbiter;

  typedef struct {
    logic [4:0]  dest;
    logic [31:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        wbEn, mdValid;
  logic [4:0]  wbDest, mdDest, qSrc1, qSrc2, rfDest;
  logic [31:0] wbVal, mdVal, rfVal;
  logic        mdReady, stallReq, hit1, hit2, rfWe, protoErr;

  int   checkCount = 0;
  int   passCount  = 0;
  bit   monOn      = 1'b0;
  exp_t mdQ[$];
  exp_t monEntry;

  always #5 clk = ~clk;

  reg_write_arbiter #(
    .DEPTH        (2),
    .STARVE_LIMIT (4),
    .AW           (5),
    .DW           (32)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .wb_en_i     (wbEn),
    .wb_dest_i   (wbDest),
    .wb_val_i    (wbVal),
    .md_valid_i  (mdValid),
    .md_dest_i   (mdDest),
    .md_val_i    (mdVal),
    .md_ready_o  (mdReady),
    .stall_req_o (stallReq),
    .q_src1_i    (qSrc1),
    .q_src2_i    (qSrc2),
    .hit1_o      (hit1),
    .hit2_o      (hit2),
    .rf_we_o     (rfWe),
    .rf_dest_o   (rfDest),
    .rf_val_o    (rfVal),
    .proto_err_o (protoErr)
  );

  // Scoreboard monitor: WB writes must pass straight through; any other write pops the md queue.
  always @(negedge clk) begin
    if (monOn) begin
      if (wbEn) begin
        checkCount++;
        if (rfWe !== (wbDest != 5'd0) ||
            (wbDest != 5'd0 && (rfDest !== wbDest || rfVal !== wbVal)))
          $display("[TB] FAIL wb_write: got we=%b dest=%0d val=%h, want dest=%0d val=%h",
                   rfWe, rfDest, rfVal, wbDest, wbVal);
        else passCount++;
      end else if (rfWe !== 1'b0) begin
        checkCount++;
        if (mdQ.size() == 0) begin
          $display("[TB] FAIL md_write_unexpected: got we=%b dest=%0d val=%h, want no write",
                   rfWe, rfDest, rfVal);
        end else begin
          monEntry = mdQ.pop_front();
          if (rfWe !== 1'b1 || rfDest !== monEntry.dest || rfVal !== monEntry.val)
            $display("[TB] FAIL md_write_order: got we=%b dest=%0d val=%h, want dest=%0d val=%h",
                     rfWe, rfDest, rfVal, monEntry.dest, monEntry.val);
          else passCount++;
        end
      end
    end
  end

  // Drive one cycle of inputs just after the edge, then wait to the sampling point.
  task automatic drive(input logic we, input logic [4:0] wd, input logic [31:0] wv,
                       input logic mv, input logic [4:0] md, input logic [31:0] mval,
                       input logic accept);
    @(posedge clk);
    #1;
    wbEn = we; wbDest = wd; wbVal = wv;
    mdValid = mv; mdDest = md; mdVal = mval;
    if (mv && accept && md != 5'd0) mdQ.push_back('{md, mval});
    #3;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1; wbEn = 1'b0; wbDest = '0; wbVal = '0;
    mdValid = 1'b0; mdDest = '0; mdVal = '0; qSrc1 = 5'd5; qSrc2 = 5'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #3;
    checkCount++; if (mdReady !== 1'b1) $display("[TB] FAIL reset_ready: got %b want 1", mdReady); else passCount++;
    checkCount++; if (stallReq !== 1'b0) $display("[TB] FAIL reset_stall: got %b want 0", stallReq); else passCount++;
    checkCount++; if (protoErr !== 1'b0) $display("[TB] FAIL reset_proto: got %b want 0", protoErr); else passCount++;
    checkCount++; if (rfWe !== 1'b0) $display("[TB] FAIL reset_we: got %b want 0", rfWe); else passCount++;
    checkCount++; if (hit1 !== 1'b0) $display("[TB] FAIL reset_hit1: got %b want 0", hit1); else passCount++;
    monOn = 1'b1;
  endtask

  task automatic test_idle_md();
    qSrc1 = 5'd5;
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h11, 1'b1);
    checkCount++; if (mdReady !== 1'b1) $display("[TB] FAIL idle_ready0: got %b want 1", mdReady); else passCount++;
`ifdef REG_WRITE_ARBITER_BYPASS_EN
    checkCount++; if (rfWe !== 1'b1 || rfDest !== 5'd5) $display("[TB] FAIL idle_bypass_write: got we=%b dest=%0d want we=1 dest=5", rfWe, rfDest); else passCount++;
`else
    checkCount++; if (rfWe !== 1'b0) $display("[TB] FAIL idle_latency: got we=%b want 0", rfWe); else passCount++;
`endif
    idle();
    checkCount++; if (mdReady !== 1'b1) $display("[TB] FAIL idle_ready1: got %b want 1", mdReady); else passCount++;
`ifdef REG_WRITE_ARBITER_BYPASS_EN
    checkCount++; if (rfWe !== 1'b0) $display("[TB] FAIL idle_no_rewrite: got we=%b want 0", rfWe); else passCount++;
`else
    checkCount++; if (rfWe !== 1'b1 || rfDest !== 5'd5 || rfVal !== 32'h11) $display("[TB] FAIL idle_write: got we=%b dest=%0d val=%h want 1/5/11", rfWe, rfDest, rfVal); else passCount++;
    checkCount++; if (hit1 !== 1'b1) $display("[TB] FAIL idle_hit_popping: got %b want 1", hit1); else passCount++;
`endif
    idle();
    checkCount++; if (rfWe !== 1'b0 || hit1 !== 1'b0) $display("[TB] FAIL idle_quiet: got we=%b hit1=%b want 0/0", rfWe, hit1); else passCount++;
  endtask

  task automatic test_wb_priority();
    qSrc1 = 5'd7; qSrc2 = 5'd9;
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd7, 32'h77, 1'b1);
    checkCount++; if (hit1 !== 1'b0 || mdReady !== 1'b1) $display("[TB] FAIL prio_c1: got hit1=%b ready=%b want 0/1", hit1, mdReady); else passCount++;
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd8, 32'h88, 1'b1);
    checkCount++; if (hit1 !== 1'b1 || mdReady !== 1'b1) $display("[TB] FAIL prio_c2: got hit1=%b ready=%b want 1/1", hit1, mdReady); else passCount++;
    qSrc1 = 5'd8;
    drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0, 1'b0);
    checkCount++; if (mdReady !== 1'b0) $display("[TB] FAIL prio_full: got ready=%b want 0", mdReady); else passCount++;
    checkCount++; if (hit1 !== 1'b1 || hit2 !== 1'b0) $display("[TB] FAIL prio_hits: got hit1=%b hit2=%b want 1/0", hit1, hit2); else passCount++;
    checkCount++; if (rfDest !== 5'd3) $display("[TB] FAIL prio_dest: got %0d want 3", rfDest); else passCount++;
    idle();
    checkCount++; if (rfDest !== 5'd7 || mdReady !== 1'b0 || stallReq !== 1'b0) $display("[TB] FAIL prio_drain1: got dest=%0d ready=%b stall=%b want 7/0/0", rfDest, mdReady, stallReq); else passCount++;
    idle();
    checkCount++; if (rfDest !== 5'd8 || mdReady !== 1'b1) $display("[TB] FAIL prio_drain2: got dest=%0d ready=%b want 8/1", rfDest, mdReady); else passCount++;
    idle();
    checkCount++; if (rfWe !== 1'b0) $display("[TB] FAIL prio_empty: got we=%b want 0", rfWe); else passCount++;
  endtask

  task automatic test_starvation();
    qSrc1 = 5'd10; qSrc2 = 5'd0;
    drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd10, 32'hA0, 1'b1);
    for (int c = 1; c <= 3; c++) begin
      drive(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'd0, 1'b0);
      checkCount++; if (stallReq !== 1'b0 || hit1 !== 1'b1) $display("[TB] FAIL starve_wait%0d: got stall=%b hit1=%b want 0/1", c, stallReq, hit1); else passCount++;
    end
    idle();
    checkCount++; if (stallReq !== 1'b1) $display("[TB] FAIL starve_stall: got %b want 1", stallReq); else passCount++;
    checkCount++; if (rfWe !== 1'b1 || rfDest !== 5'd10 || rfVal !== 32'hA0) $display("[TB] FAIL starve_drain: got we=%b dest=%0d val=%h want 1/10/a0", rfWe, rfDest, rfVal); else passCount++;
    idle();
    checkCount++; if (stallReq !== 1'b0 || rfWe !== 1'b0) $display("[TB] FAIL starve_release: got stall=%b we=%b want 0/0", stallReq, rfWe); else passCount++;
  endtask

  task automatic test_zero_reg();
    qSrc1 = 5'd0; qSrc2 = 5'd0;
    drive(1'b1, 5'd6, 32'h66, 1'b1, 5'd0, 32'h55, 1'b1);
    checkCount++; if (hit1 !== 1'b0 || hit2 !== 1'b0) $display("[TB] FAIL zero_hit_push: got %b/%b want 0/0", hit1, hit2); else passCount++;
    idle();
    checkCount++; if (rfWe !== 1'b0 || hit1 !== 1'b0 || hit2 !== 1'b0) $display("[TB] FAIL zero_pop: got we=%b hits=%b/%b want 0/0/0", rfWe, hit1, hit2); else passCount++;
    drive(1'b1, 5'd6, 32'h66, 1'b1, 5'd11, 32'hB1, 1'b1);
    checkCount++; if (mdReady !== 1'b1) $display("[TB] FAIL zero_ready_a: got %b want 1", mdReady); else passCount++;
    drive(1'b1, 5'd6, 32'h66, 1'b1, 5'd12, 32'hB2, 1'b1);
    checkCount++; if (mdReady !== 1'b1) $display("[TB] FAIL zero_ready_b: got %b want 1", mdReady); else passCount++;
    qSrc1 = 5'd11;
    idle();
    checkCount++; if (mdReady !== 1'b0 || rfDest !== 5'd11 || hit1 !== 1'b1) $display("[TB] FAIL zero_refill: got ready=%b dest=%0d hit1=%b want 0/11/1", mdReady, rfDest, hit1); else passCount++;
    idle();
    checkCount++; if (rfDest !== 5'd12) $display("[TB] FAIL zero_second: got %0d want 12", rfDest); else passCount++;
    idle();
  endtask

  task automatic test_back_to_back();
    qSrc1 = 5'd0;
    drive(1'b1, 5'd6, 32'h66, 1'b1, 5'd16, 32'h16, 1'b1);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'(17 + k), 32'(23 + k), 1'b1);
      checkCount++; if (rfDest !== 5'(16 + k) || mdReady !== 1'b1) $display("[TB] FAIL b2b_%0d: got dest=%0d ready=%b want %0d/1", k, rfDest, mdReady, 16 + k); else passCount++;
    end
    idle();
    checkCount++; if (rfDest !== 5'd19) $display("[TB] FAIL b2b_last: got %0d want 19", rfDest); else passCount++;
    idle();
    checkCount++; if (rfWe !== 1'b0 || stallReq !== 1'b0) $display("[TB] FAIL b2b_quiet: got we=%b stall=%b want 0/0", rfWe, stallReq); else passCount++;
  endtask

  task automatic test_proto_err_reset();
    qSrc1 = 5'd13;
    drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd13, 32'hD0, 1'b1);
    drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd14, 32'hE0, 1'b1);
    drive(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'd0, 1'b0);
    drive(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'd0, 1'b0);
    checkCount++; if (stallReq !== 1'b0 || mdReady !== 1'b0) $display("[TB] FAIL proto_pre: got stall=%b ready=%b want 0/0", stallReq, mdReady); else passCount++;
    drive(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'd0, 1'b0);
    checkCount++; if (stallReq !== 1'b1 || protoErr !== 1'b0 || rfDest !== 5'd4) $display("[TB] FAIL proto_force: got stall=%b err=%b dest=%0d want 1/0/4", stallReq, protoErr, rfDest); else passCount++;
    drive(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'd0, 1'b0);
    checkCount++; if (stallReq !== 1'b1 || protoErr !== 1'b1) $display("[TB] FAIL proto_set: got stall=%b err=%b want 1/1", stallReq, protoErr); else passCount++;
    @(posedge clk);
    #1;
    rst = 1'b1; wbEn = 1'b1; wbDest = 5'd2; wbVal = 32'h22; mdValid = 1'b0;
    mdQ.delete();
    #3;
    checkCount++; if (rfWe !== 1'b1 || rfDest !== 5'd2 || protoErr !== 1'b1) $display("[TB] FAIL proto_rst_cycle: got we=%b dest=%0d err=%b want 1/2/1", rfWe, rfDest, protoErr); else passCount++;
    @(posedge clk);
    #1;
    rst = 1'b0; wbEn = 1'b0; wbDest = 5'd0; wbVal = 32'd0;
    #3;
    checkCount++; if (rfWe !== 1'b0 || mdReady !== 1'b1 || protoErr !== 1'b0 || stallReq !== 1'b0 || hit1 !== 1'b0)
      $display("[TB] FAIL proto_after_rst: got we=%b ready=%b err=%b stall=%b hit1=%b want 0/1/0/0/0", rfWe, mdReady, protoErr, stallReq, hit1);
    else passCount++;
    idle();
    checkCount++; if (rfWe !== 1'b0) $display("[TB] FAIL proto_discard: got we=%b want 0", rfWe); else passCount++;
  endtask

  task automatic test_bypass();
`ifdef REG_WRITE_ARBITER_BYPASS_EN
    qSrc1 = 5'd9;
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hAB, 1'b1);
    checkCount++; if (rfWe !== 1'b1 || rfDest !== 5'd9 || rfVal !== 32'hAB || hit1 !== 1'b1)
      $display("[TB] FAIL bypass_write: got we=%b dest=%0d val=%h hit1=%b want 1/9/ab/1", rfWe, rfDest, rfVal, hit1);
    else passCount++;
    idle();
    checkCount++; if (rfWe !== 1'b0 || mdReady !== 1'b1) $display("[TB] FAIL bypass_not_pushed: got we=%b ready=%b want 0/1", rfWe, mdReady); else passCount++;
`endif
  endtask

  initial begin
    test_reset();
    test_idle_md();
    test_wb_priority();
    test_starvation();
    test_zero_reg();
    test_back_to_back();
    test_proto_err_reset();
    test_bypass();
    idle();
    checkCount++;
    if (mdQ.size() != 0) $display("[TB] FAIL scoreboard_drain: got %0d pending want 0", mdQ.size());
    else passCount++;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Shares the register file's single write port between two requesters: the WB pipeline stage and the multi-cycle mul/div unit.
- WB always wins the port. Mul/div results wait in a small FIFO and drain on cycles when WB does not write.
- An age counter forces a WB stall when a buffered result starves too long.
- Exposes pending-destination hit flags to the hazard unit. Sits between WB/mul-div and the register file's write inputs.

Parameters:
- DEPTH, 2, mul/div pending FIFO entries (power of 2, >= 2)
- STARVE_LIMIT, 4, cycles the FIFO head may wait before stall_req asserts (>= 1)
- AW, 5, register address width
- DW, 32, data width

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  synchronous active-high reset
- wb_en  in  1  WB write request (no backpressure)
- wb_dest  in  AW  WB destination register
- wb_val  in  DW  WB write data
- md_valid  in  1  mul/div result valid
- md_dest  in  AW  mul/div destination register
- md_val  in  DW  mul/div result data
- md_ready  out  1  FIFO can accept; a transfer occurs when md_valid && md_ready
- stall_req  out  1  registered; the pipeline must hold wb_en=0 while this is high
- q_src1, q_src2  in  AW  hazard-unit query addresses
- hit1, hit2  out  1  a FIFO entry (or bypassing request) targets q_srcN, with q_srcN != 0
- rf_we  out  1  register-file write enable, active-high
- rf_dest  out  AW  register-file write address
- rf_val  out  DW  register-file write data
- proto_err  out  1  sticky: wb_en was seen high while stall_req was high

Behaviour:
- Reset: FIFO empty, age=0, state=IDLE, stall_req=0, proto_err=0. md_ready=1 in the cycle after reset. rf_we/hit1/hit2 are 0 unless driven by the current-cycle wb_en or md inputs.
- Write-port mux (combinational):
  - wb_en=1: rf_we=1, rf_dest=wb_dest, rf_val=wb_val. WB latency is 0.
  - else FIFO non-empty: write the FIFO head and pop it this cycle.
  - else: rf_we=0, rf_dest=0, rf_val=0.
- Register 0: any selected write with dest=0 drives rf_we=0 but is still consumed (FIFO head is popped).
- md_ready = (count < DEPTH), derived from registered count only. A pop in the same cycle does not raise md_ready.
- Push and pop in the same cycle is legal at any count < DEPTH. Pointers wrap modulo DEPTH.
- FIFO order is strict. A mul/div result is written no earlier than 1 cycle after acceptance.
- Age counter:
  - Cleared on every pop and whenever the FIFO is empty.
  - Otherwise increments each cycle the head is blocked by wb_en, saturating at STARVE_LIMIT.
- State machine:
  - IDLE (FIFO empty) -> WAIT on push.
  - WAIT -> IDLE when the last entry pops with no push.
  - WAIT -> FORCE when age reaches STARVE_LIMIT-1 and the head is still blocked this cycle.
  - FORCE: stall_req=1; the head drains. Exit to WAIT or IDLE on the cycle after the pop, so stall_req is high for exactly 1 cycle per starvation event.
- Contract violation: wb_en=1 during FORCE means WB still wins, proto_err sets (sticky until rst), and the state stays FORCE.
- Hit flags: compare q_src1/q_src2 against all valid FIFO entries.
  - A FIFO entry being popped this cycle still counts as a hit.
  - The register file has no internal forwarding, so the hazard unit must stall on a hit.
- Reset mid-operation: pending FIFO contents are discarded with no write. The rst cycle itself still passes a combinational WB write through.

Optional Feature:
- Macro: REG_WRITE_ARBITER_BYPASS_EN.
- Defined: when the FIFO is empty, wb_en=0, state≠FORCE and md_valid=1, the md request is written to the port in the same cycle (0 latency) and is not pushed. The hit flags include the bypassing md_dest.
- Undefined: every md result goes through the FIFO (latency >= 1).

Decomposition:
- Package reg_arb_pkg:
  - state enum {IDLE, WAIT, FORCE}.
  - Entry struct {dest[AW-1:0], val[DW-1:0]}.
  - Localparam REG_ZERO = 0.
- One natural sub-module, reg_arb_fifo:
  - Parameterised DEPTH×entry FIFO with count.
  - Exposes full, empty and head.
  - Exposes per-entry valid/dest vectors for the hit compare.

Test Plan:
- Idle md result: after reset, md_valid with dest=5, val=0x11 -> next cycle rf_we=1, rf_dest=5, rf_val=0x11, and md_ready is 1 throughout.
- WB priority: wb_en=1 continuously (dest=3) while md pushes dest=7 and dest=8 -> rf_dest=3 each cycle, md_ready=0 after two pushes, and hit1=1 for q_src1=8.
- Starvation, STARVE_LIMIT=4: head blocked 3 cycles -> stall_req=1 on the 4th, bench drops wb_en, head writes, and stall_req=0 the cycle after.
- Zero register: md result dest=0 -> rf_we stays 0, the FIFO pops, and hit flags are never set for q_src=0.
- Protocol error plus reset: wb_en high during stall_req -> proto_err=1 and held; rst with 2 entries pending -> no writes, md_ready=1, proto_err=0.
- Bypass (macro defined): empty FIFO, wb_en=0, md_valid with dest=9, val=0xAB -> same-cycle rf_we=1, rf_dest=9, rf_val=0xAB, and count remains 0.
